// File: rtl/edge_detector_multi_if.sv
// Bundle of per-channel pin inputs, filter/mode/clear controls and the
// qualified edge outputs exchanged between the edge detector and its consumer.
interface edge_detector_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]    i_sig;
  logic [CNT_W-1:0] i_filt_len;
  logic [2*CH-1:0]  i_mode;
  logic [CH-1:0]    i_clr;

  logic [CH-1:0]    o_level;
  logic [CH-1:0]    o_posedge;
  logic [CH-1:0]    o_negedge;
  logic [CH-1:0]    o_event;
  logic [CH-1:0]    o_sticky;
  logic             o_irq;

  modport master (
    output i_sig, i_filt_len, i_mode, i_clr,
    input  o_level, o_posedge, o_negedge, o_event, o_sticky, o_irq
  );

  modport slave (
    input  i_sig, i_filt_len, i_mode, i_clr,
    output o_level, o_posedge, o_negedge, o_event, o_sticky, o_irq
  );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, registered edge
// pulses, mode-qualified events and sticky flags with an aggregated interrupt.
module edge_detector_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  edge_detector_multi_if.slave  bus
);

  logic [SYNC_STAGES-1:0] r_sync [CH];
  logic [CNT_W-1:0]       r_cnt  [CH];
  logic [CH-1:0]          r_level;
  logic [CH-1:0]          r_posedge;
  logic [CH-1:0]          r_negedge;
  logic [CH-1:0]          r_event;
  logic [CH-1:0]          r_sticky;

  logic [CH-1:0]          w_s;
  logic [CH-1:0]          w_flip;
  logic [CH-1:0]          w_pos;
  logic [CH-1:0]          w_neg;
  logic [CH-1:0]          w_event;
  logic [CH-1:0]          w_sticky_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt [CH];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_s          = '0;
    w_flip       = '0;
    w_pos        = '0;
    w_neg        = '0;
    w_event      = '0;
    w_sticky_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      w_cnt_nxt[i] = '0;
    end

    for (int i = 0; i < CH; i++) begin
      w_s[i] = r_sync[i][SYNC_STAGES-1];
      // Counter only runs while the synchronised input disagrees with the filtered level.
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] >= bus.i_filt_len) begin
          w_flip[i] = 1'b1;
        end else if (r_cnt[i] != '1) begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end else begin
          w_cnt_nxt[i] = r_cnt[i];
        end
      end
    end

    w_pos = w_flip & w_s;
    w_neg = w_flip & ~w_s;

    for (int i = 0; i < CH; i++) begin
      w_event[i] = (w_pos[i] & bus.i_mode[2*i]) | (w_neg[i] & bus.i_mode[2*i+1]);
    end

    // A new event wins over a simultaneous software clear.
    w_sticky_nxt = w_event | (r_sticky & ~bus.i_clr);
  end

  // NOTE: synchroniser and filter arrays are reset too, so a channel never
  // emits a spurious edge from stale history after reset is released.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < CH; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_level   <= '0;
      r_posedge <= '0;
      r_negedge <= '0;
      r_event   <= '0;
      r_sticky  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.i_sig[i]};
        r_cnt[i]  <= w_cnt_nxt[i];
      end
      r_level   <= r_level ^ w_flip;
      r_posedge <= w_pos;
      r_negedge <= w_neg;
      r_event   <= w_event;
      r_sticky  <= w_sticky_nxt;
    end
  end

  assign bus.o_level   = r_level;
  assign bus.o_posedge = r_posedge;
  assign bus.o_negedge = r_negedge;
  assign bus.o_event   = r_event;
  assign bus.o_sticky  = r_sticky;
  assign bus.o_irq     = |r_sticky;

endmodule
